mem_stage_ctrl: RTL and testbench

M-stage data-memory request controller sitting directly upstream of the cache/AXI memory subsystem. It turns the pipeline's E/M-stage load/store information into the subsystem's `d` request interface. It holds each request stable until the subsystem returns valid, and stalls the pipeline while waiting. It also lane-aligns store data, extracts and sign-extends load data, detects misaligned accesses, and retires in-flight uncached accesses safely across flushes.

---
 rtl/mem_stage_ctrl.sv | 176 +++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - M-stage data-memory request controller
module mem_stage_ctrl #(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_e_va,
  input  logic        i_m_valid,
  input  logic        i_m_load,
  input  logic        i_m_store,
  input  logic [2:0]  i_m_op,
  input  logic [31:0] i_m_pa,
  input  logic        i_m_cached,
  input  logic [31:0] i_m_wdata,
  input  logic        i_wb_stall,
  input  logic        i_flush,
  output logic [31:0] o_d_va,
  output logic [31:0] o_d_phyaddr,
  output logic        o_d_cached,
  output logic        o_d_read,
  output logic        o_d_write,
  output logic [2:0]  o_d_size,
  output logic [31:0] o_d_indata,
  input  logic [31:0] i_d_outdata,
  input  logic        i_d_valid,
  output logic        o_stall,
  output logic [31:0] o_load_data,
  output logic        o_adel,
  output logic        o_ades
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] cap_pa_q, cap_pa_d;
  logic [2:0]  cap_op_q, cap_op_d;
  logic        cap_cached_q, cap_cached_d;
  logic        cap_read_q, cap_read_d;
  logic        cap_write_q, cap_write_d;
  logic [31:0] cap_data_q, cap_data_d;
  logic [31:0] ld_latch_q, ld_latch_d;

  logic misaligned;
  logic req;

  function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] w);
    case (sz)
      2'b00:   lane_data = {4{w[7:0]}};
      2'b01:   lane_data = {2{w[15:0]}};
      default: lane_data = w;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] op, input logic [1:0] a,
                                               input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{a, 3'b000} +: 8];
    h = a[1] ? d[31:16] : d[15:0];
    case (op[1:0])
      2'b00:   load_extract = op[2] ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   load_extract = op[2] ? {16'b0, h} : {{16{h[15]}}, h};
      default: load_extract = d;
    endcase
  endfunction

  assign misaligned = ALIGN_CHECK &&
                      ((i_m_op[1:0] == 2'b01 && i_m_pa[0]) ||
                       (i_m_op[1:0] == 2'b10 && i_m_pa[1:0] != 2'b00));
  assign req = i_m_valid && (i_m_load || i_m_store) && !misaligned && !i_flush &&
               (state_q == S_IDLE || state_q == S_WAIT);

  assign o_d_va = i_e_va;
  assign o_adel = i_m_valid && i_m_load && misaligned;
  assign o_ades = i_m_valid && i_m_store && misaligned;

  always_comb begin
    state_d      = state_q;
    cap_pa_d     = cap_pa_q;
    cap_op_d     = cap_op_q;
    cap_cached_d = cap_cached_q;
    cap_read_d   = cap_read_q;
    cap_write_d  = cap_write_q;
    cap_data_d   = cap_data_q;
    ld_latch_d   = ld_latch_q;
    o_d_phyaddr  = 32'b0;
    o_d_cached   = 1'b0;
    o_d_read     = 1'b0;
    o_d_write    = 1'b0;
    o_d_size     = 3'b0;
    o_d_indata   = 32'b0;
    o_stall      = 1'b0;
    o_load_data  = 32'b0;

    // Outside IDLE the subsystem sees the captured copy so nothing moves mid-access.
    if (state_q != S_IDLE) begin
      o_d_phyaddr = cap_pa_q;
      o_d_cached  = cap_cached_q;
      o_d_size    = {1'b0, cap_op_q[1:0]};
      o_d_indata  = cap_data_q;
      o_d_read    = cap_read_q && state_q != S_DONE;
      o_d_write   = cap_write_q && state_q != S_DONE;
    end

    case (state_q)
      S_IDLE: begin
        if (req) begin
          o_d_phyaddr  = i_m_pa;
          o_d_cached   = i_m_cached;
          o_d_size     = {1'b0, i_m_op[1:0]};
          o_d_indata   = lane_data(i_m_op[1:0], i_m_wdata);
          o_d_read     = i_m_load;
          o_d_write    = i_m_store;
          cap_pa_d     = i_m_pa;
          cap_op_d     = i_m_op;
          cap_cached_d = i_m_cached;
          cap_read_d   = i_m_load;
          cap_write_d  = i_m_store;
          cap_data_d   = lane_data(i_m_op[1:0], i_m_wdata);
          if (i_d_valid) begin
            o_load_data = load_extract(i_m_op, i_m_pa[1:0], i_d_outdata);
            if (i_wb_stall) begin
              ld_latch_d = o_load_data;
              state_d    = S_DONE;
            end
          end else begin
            o_stall = 1'b1;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (i_d_valid) begin
          o_load_data = load_extract(cap_op_q, cap_pa_q[1:0], i_d_outdata);
          ld_latch_d  = o_load_data;
          state_d     = i_wb_stall ? S_DONE : S_IDLE;
        end else begin
          o_stall = 1'b1;
          if (i_flush) state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        o_load_data = ld_latch_q;
        if (i_flush || !i_wb_stall) state_d = S_IDLE;
      end
      S_DRAIN: begin
        o_stall = 1'b1;
        if (i_d_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      cap_pa_q     <= 32'b0;
      cap_op_q     <= 3'b0;
      cap_cached_q <= 1'b0;
      cap_read_q   <= 1'b0;
      cap_write_q  <= 1'b0;
      cap_data_q   <= 32'b0;
      ld_latch_q   <= 32'b0;
    end else begin
      state_q      <= state_d;
      cap_pa_q     <= cap_pa_d;
      cap_op_q     <= cap_op_d;
      cap_cached_q <= cap_cached_d;
      cap_read_q   <= cap_read_d;
      cap_write_q  <= cap_write_d;
      cap_data_q   <= cap_data_d;
      ld_latch_q   <= ld_latch_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - randomized self-checking bench for mem_stage_ctrl
module tb_mem_stage_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_e_va;
  logic        i_m_valid, i_m_load, i_m_store, i_m_cached;
  logic [2:0]  i_m_op;
  logic [31:0] i_m_pa, i_m_wdata;
  logic        i_wb_stall, i_flush;
  logic [31:0] o_d_va, o_d_phyaddr, o_d_indata, i_d_outdata, o_load_data;
  logic        o_d_cached, o_d_read, o_d_write, i_d_valid, o_stall, o_adel, o_ades;
  logic [2:0]  o_d_size;

  int n_tests = 0;
  int n_fail  = 0;

  mem_stage_ctrl #(.ALIGN_CHECK(1'b1)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_e_va(i_e_va),
    .i_m_valid(i_m_valid), .i_m_load(i_m_load), .i_m_store(i_m_store),
    .i_m_op(i_m_op), .i_m_pa(i_m_pa), .i_m_cached(i_m_cached), .i_m_wdata(i_m_wdata),
    .i_wb_stall(i_wb_stall), .i_flush(i_flush),
    .o_d_va(o_d_va), .o_d_phyaddr(o_d_phyaddr), .o_d_cached(o_d_cached),
    .o_d_read(o_d_read), .o_d_write(o_d_write), .o_d_size(o_d_size),
    .o_d_indata(o_d_indata), .i_d_outdata(i_d_outdata), .i_d_valid(i_d_valid),
    .o_stall(o_stall), .o_load_data(o_load_data), .o_adel(o_adel), .o_ades(o_ades)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_lanes(input logic [2:0] op, input logic [31:0] w);
    if (op[1:0] == 2'd0)      return (w & 32'hFF) * 32'h0101_0101;
    else if (op[1:0] == 2'd1) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] pa,
                                             input logic [31:0] d);
    logic [31:0] v;
    if (op[1:0] == 2'd0) begin
      v = (d >> (8 * pa[1:0])) & 32'hFF;
      if (!op[2] && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (op[1:0] == 2'd1) begin
      v = (d >> (16 * pa[1])) & 32'hFFFF;
      if (!op[2] && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = d;
    end
    return v;
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
    i_e_va = $urandom;
  endtask

  task automatic idle_inputs();
    i_m_valid = 0; i_m_load = 0; i_m_store = 0; i_d_valid = 0;
    i_flush = 0; i_wb_stall = 0;
  endtask

  task automatic check_ctl(input string tag, input bit stall, input bit rd, input bit wr,
                           input bit adel, input bit ades);
    @(negedge i_clk);
    check_eq({tag, ".va"}, o_d_va, i_e_va);
    check_eq({tag, ".stall"}, {31'b0, o_stall}, {31'b0, stall});
    check_eq({tag, ".read"}, {31'b0, o_d_read}, {31'b0, rd});
    check_eq({tag, ".write"}, {31'b0, o_d_write}, {31'b0, wr});
    check_eq({tag, ".adel"}, {31'b0, o_adel}, {31'b0, adel});
    check_eq({tag, ".ades"}, {31'b0, o_ades}, {31'b0, ades});
  endtask

  task automatic check_fields(input string tag, input logic [31:0] pa, input logic [2:0] op,
                              input bit cached, input logic [31:0] lanes);
    check_eq({tag, ".pa"}, o_d_phyaddr, pa);
    check_eq({tag, ".size"}, {29'b0, o_d_size}, {30'b0, op[1:0]});
    check_eq({tag, ".cached"}, {31'b0, o_d_cached}, {31'b0, cached});
    check_eq({tag, ".indata"}, o_d_indata, lanes);
  endtask

  // lat: cycles of stall before i_d_valid (0 = hit); hold: cycles spent held by writeback
  // once data returns; flush_at: cycle of a flush during the miss (0 = none).
  task automatic run_txn(input string tag, input bit is_load, input logic [2:0] op,
                         input logic [31:0] pa, input bit cached, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int lat, input int hold,
                         input int flush_at);
    bit mis, drain;
    logic [31:0] lanes, ld;
    mis   = (op[1:0] == 2'd1 && pa[0]) || (op[1:0] == 2'd2 && pa[1:0] != 2'd0);
    drain = flush_at > 0 && flush_at < lat;
    lanes = model_lanes(op, wdata);
    ld    = model_load(op, pa, rdata);
    i_m_valid = 1; i_m_load = is_load; i_m_store = !is_load; i_m_op = op;
    i_m_pa = pa; i_m_cached = cached; i_m_wdata = wdata;
    i_flush = 0; i_wb_stall = 0;
    if (mis) begin
      i_d_valid = 0;
      check_ctl({tag, ".mis"}, 0, 0, 0, is_load, !is_load);
      step();
      idle_inputs();
      return;
    end
    for (int c = 0; c <= lat; c++) begin
      i_d_valid   = (c == lat);
      i_d_outdata = (c == lat) ? rdata : $urandom;
      i_flush     = drain && c == flush_at;
      i_wb_stall  = !drain && c == lat && hold > 0;
      if (drain && c > flush_at) begin
        i_m_valid = 0; i_m_pa = $urandom; i_m_wdata = $urandom;
        i_m_op = 3'($urandom); i_m_cached = 1'($urandom);
      end
      check_ctl({tag, ".acc"}, (c < lat) || (drain && c > flush_at), is_load, !is_load, 0, 0);
      check_fields({tag, ".acc"}, pa, op, cached, lanes);
      if (c == lat && drain) check_eq({tag, ".drain_ld"}, o_load_data, 32'b0);
      else if (c == lat && is_load) check_eq({tag, ".ld"}, o_load_data, ld);
      step();
    end
    i_flush = 0;
    i_d_valid = 0;
    if (!drain) begin
      for (int h = 1; h <= hold; h++) begin
        i_wb_stall  = (h < hold);
        i_d_outdata = $urandom;
        check_ctl({tag, ".done"}, 0, 0, 0, 0, 0);
        if (is_load) check_eq({tag, ".done_ld"}, o_load_data, ld);
        step();
      end
    end
    idle_inputs();
    check_ctl({tag, ".gap"}, 0, 0, 0, 0, 0);
    step();
  endtask

  initial begin
    logic [2:0] ops [5];
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b100; ops[4] = 3'b101;
    i_e_va = 32'h0; i_m_op = 0; i_m_pa = 0; i_m_cached = 0; i_m_wdata = 0; i_d_outdata = 0;
    idle_inputs();
    i_rst = 1;
    step(); step();
    i_rst = 0;
    check_ctl("reset", 0, 0, 0, 0, 0);
    check_eq("reset.pa", o_d_phyaddr, 32'b0);
    check_eq("reset.indata", o_d_indata, 32'b0);
    check_eq("reset.ld", o_load_data, 32'b0);
    step();

    run_txn("lb_hit",  1, 3'b000, 32'h1003, 1, 0, 32'h80FF_1234, 0, 0, 0);
    run_txn("lbu_hit", 1, 3'b100, 32'h1003, 1, 0, 32'h80FF_1234, 0, 0, 0);
    run_txn("sh_unc",  0, 3'b001, 32'h2002, 0, 32'h0000_BEEF, 0, 5, 0, 0);
    run_txn("lw_mis",  1, 3'b010, 32'h3001, 1, 0, 0, 0, 0, 0);
    run_txn("sw_mis",  0, 3'b010, 32'h3002, 1, 32'h1234_5678, 0, 0, 0, 0);
    run_txn("lw_done", 1, 3'b010, 32'h3004, 0, 0, 32'hCAFE_F00D, 2, 3, 0);
    run_txn("lh_drain", 1, 3'b001, 32'h5002, 0, 0, 32'h1357_9BDF, 5, 0, 2);

    i_m_valid = 1; i_m_load = 1; i_m_op = 3'b010; i_m_pa = 32'h6000; i_m_cached = 1;
    i_flush = 1;
    check_ctl("flush_idle", 0, 0, 0, 0, 0);
    step();
    idle_inputs();
    step();

    i_m_valid = 1; i_m_load = 1; i_m_op = 3'b010; i_m_pa = 32'h4000; i_m_cached = 0;
    check_ctl("rst_wait.issue", 1, 1, 0, 0, 0);
    step();
    i_rst = 1;
    step();
    i_rst = 0;
    idle_inputs();
    check_ctl("rst_wait.after", 0, 0, 0, 0, 0);
    check_eq("rst_wait.pa", o_d_phyaddr, 32'b0);
    check_eq("rst_wait.ld", o_load_data, 32'b0);
    step();

    for (int i = 0; i < 60; i++) begin
      bit          ld_kind;
      logic [2:0]  op;
      int          lat, fa;
      ld_kind = 1'($urandom);
      op  = ld_kind ? ops[$urandom_range(0, 4)] : ops[$urandom_range(0, 2)];
      lat = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 6);
      fa  = (lat >= 2 && $urandom_range(0, 3) == 0) ? $urandom_range(1, lat - 1) : 0;
      run_txn("rand", ld_kind, op, $urandom, 1'($urandom), $urandom, $urandom,
              lat, $urandom_range(0, 3), fa);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
